// File: rtl/dec_exe_pipe_reg_if.sv
// Decode->Execute beat bundle: handshake plus decoded control, operands and register addresses.
// The master side drives a beat; the slave side accepts it and returns ready.
interface dec_exe_pipe_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 9
) ();
    logic                  valid;
    logic                  ready;
    logic [CTRL_W-1:0]     ctrl;
    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     pcplus4;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;

    modport master (output valid, ctrl, rd1, rd2, imm, pcplus4, rs, rt, rd, input ready);
    modport slave  (input valid, ctrl, rd1, rd2, imm, pcplus4, rs, rt, rd, output ready);
endinterface

// File: rtl/dec_exe_pipe_reg.sv
// Decode/Execute pipeline register with valid/ready handshake, optional skid buffer,
// synchronous flush that inserts bubbles, and a saturating stall-cycle counter.
module dec_exe_pipe_reg #(
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int CTRL_W      = 9,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    dec_exe_pipe_reg_if.slave      inBus,
    dec_exe_pipe_reg_if.master     outBus,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    localparam int BEAT_W = CTRL_W + 4 * DATA_W + 3 * REG_ADDR_W;

    logic [BEAT_W-1:0] inBeat;
    logic [BEAT_W-1:0] mData;
    logic [CTRL_W-1:0] mCtrl;
    logic              mValid;
    logic              inReady;
    logic              accept;
    logic              consume;

    assign inBeat  = {inBus.ctrl, inBus.rd1, inBus.rd2, inBus.imm, inBus.pcplus4,
                      inBus.rs, inBus.rt, inBus.rd};
    assign accept  = inBus.valid & inReady;
    assign consume = mValid & outBus.ready;
    assign inBus.ready = inReady;

    generate
        if (SKID != 0) begin : gSkid
            logic              sValid;
            logic [BEAT_W-1:0] sData;

            // Ready comes straight from a flop, so out_ready never reaches in_ready.
            assign inReady = !sValid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mValid <= 1'b0;
                    sValid <= 1'b0;
                    mData  <= '0;
                    sData  <= '0;
                end else if (flush) begin
                    mValid <= 1'b0;
                    sValid <= 1'b0;
                end else if (!mValid || consume) begin
                    if (sValid) begin
                        mValid <= 1'b1;
                        mData  <= sData;
                        sValid <= accept;
                        if (accept) begin
                            sData <= inBeat;
                        end
                    end else begin
                        mValid <= accept;
                        if (accept) begin
                            mData <= inBeat;
                        end
                    end
                end else if (accept) begin
                    sValid <= 1'b1;
                    sData  <= inBeat;
                end
            end
        end else begin : gNoSkid
            assign inReady = !mValid | outBus.ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mValid <= 1'b0;
                    mData  <= '0;
                end else if (flush) begin
                    mValid <= 1'b0;
                end else if (accept) begin
                    mValid <= 1'b1;
                    mData  <= inBeat;
                end else if (consume) begin
                    mValid <= 1'b0;
                end
            end
        end
    endgenerate

    assign {mCtrl, outBus.rd1, outBus.rd2, outBus.imm, outBus.pcplus4,
            outBus.rs, outBus.rt, outBus.rd} = mData;
    assign outBus.valid = mValid;
    // Bubbles carry an all-zero control bundle so they never write state downstream.
    assign outBus.ctrl  = mValid ? mCtrl : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (mValid && !outBus.ready && stall_cnt != {STALL_CNT_W{1'b1}}) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_dec_exe_pipe_reg.sv
// Randomised and directed checks of dec_exe_pipe_reg (skid, no-skid and 4-bit stall counter builds)
// against a FIFO-style reference model.
module tb_dec_exe_pipe_reg;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 9;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [15:0] stall1;
    logic [15:0] stall0;
    logic [3:0]  stallS;

    int checks = 0;
    int errors = 0;

    beat_t q1[$];
    beat_t q0[$];
    int    m1Stall = 0;
    int    m0Stall = 0;
    beat_t cur1, cur0;

    dec_exe_pipe_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW)) i1();
    dec_exe_pipe_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW)) o1();
    dec_exe_pipe_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW)) i0();
    dec_exe_pipe_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW)) o0();
    dec_exe_pipe_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW)) iSat();
    dec_exe_pipe_reg_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW)) oSat();

    dec_exe_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW), .SKID(1), .STALL_CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .inBus(i1), .outBus(o1), .stall_cnt(stall1));
    dec_exe_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW), .SKID(0), .STALL_CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .inBus(i0), .outBus(o0), .stall_cnt(stall0));
    dec_exe_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW), .SKID(1), .STALL_CNT_W(4)) dutSat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .inBus(iSat), .outBus(oSat), .stall_cnt(stallS));

    always #5 clk = ~clk;

    function automatic beat_t mkBeat(input logic [DW-1:0] r1, input logic [CW-1:0] c);
        beat_t b;
        b.ctrl = c;
        b.rd1  = r1;
        b.rd2  = $urandom;
        b.imm  = $urandom;
        b.pc   = $urandom;
        b.rs   = AW'($urandom_range(0, 31));
        b.rt   = AW'($urandom_range(0, 31));
        b.rd   = AW'($urandom_range(0, 31));
        return b;
    endfunction

    function automatic beat_t out1();
        beat_t b;
        b.ctrl = o1.ctrl; b.rd1 = o1.rd1; b.rd2 = o1.rd2; b.imm = o1.imm;
        b.pc = o1.pcplus4; b.rs = o1.rs; b.rt = o1.rt; b.rd = o1.rd;
        return b;
    endfunction

    function automatic beat_t out0();
        beat_t b;
        b.ctrl = o0.ctrl; b.rd1 = o0.rd1; b.rd2 = o0.rd2; b.imm = o0.imm;
        b.pc = o0.pcplus4; b.rs = o0.rs; b.rt = o0.rt; b.rd = o0.rd;
        return b;
    endfunction

    task automatic drive1(input logic v, input beat_t b);
        cur1 = b;
        i1.valid = v; i1.ctrl = b.ctrl; i1.rd1 = b.rd1; i1.rd2 = b.rd2; i1.imm = b.imm;
        i1.pcplus4 = b.pc; i1.rs = b.rs; i1.rt = b.rt; i1.rd = b.rd;
    endtask

    task automatic drive0(input logic v, input beat_t b);
        cur0 = b;
        i0.valid = v; i0.ctrl = b.ctrl; i0.rd1 = b.rd1; i0.rd2 = b.rd2; i0.imm = b.imm;
        i0.pcplus4 = b.pc; i0.rs = b.rs; i0.rt = b.rt; i0.rd = b.rd;
    endtask

    task automatic driveS(input logic v, input beat_t b);
        iSat.valid = v; iSat.ctrl = b.ctrl; iSat.rd1 = b.rd1; iSat.rd2 = b.rd2; iSat.imm = b.imm;
        iSat.pcplus4 = b.pc; iSat.rs = b.rs; iSat.rt = b.rt; iSat.rd = b.rd;
    endtask

    task automatic clearModels();
        q1.delete();
        q0.delete();
        m1Stall = 0;
        m0Stall = 0;
    endtask

    // Advance one clock; the model treats each build as a FIFO (capacity 2 with skid, 1 without).
    task automatic tick();
        logic acc;
        @(posedge clk);
        acc = i1.valid && (q1.size() < 2);
        if (q1.size() != 0 && !o1.ready && m1Stall < 65535) m1Stall++;
        if (flush) q1.delete();
        else begin
            if (q1.size() != 0 && o1.ready) void'(q1.pop_front());
            if (acc) q1.push_back(cur1);
        end
        acc = i0.valid && (q0.size() == 0 || o0.ready);
        if (q0.size() != 0 && !o0.ready && m0Stall < 65535) m0Stall++;
        if (flush) q0.delete();
        else begin
            if (q0.size() != 0 && o0.ready) void'(q0.pop_front());
            if (acc) q0.push_back(cur0);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        beat_t b;
        checks += 4;
        if (o1.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o1.valid); end
        if (o1.ctrl !== 9'h000) begin errors++; $display("FAIL reset_ctrl got %h want 000", o1.ctrl); end
        if (i1.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", i1.ready); end
        if (stall1 !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall1); end
        // Fill both entries while stalled, then reset between clock edges.
        o1.ready = 1'b0;
        b = mkBeat(32'h1, 9'h1FF); drive1(1'b1, b); tick();
        b = mkBeat(32'h2, 9'h1FF); drive1(1'b1, b); tick();
        drive1(1'b0, b); tick();
        checks += 2;
        if (i1.ready !== 1'b0) begin errors++; $display("FAIL prereset_ready got %b want 0", i1.ready); end
        if (stall1 == 16'd0) begin errors++; $display("FAIL prereset_stall got %0d want nonzero", stall1); end
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (o1.valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got %b want 0", o1.valid); end
        if (o1.ctrl !== 9'h000) begin errors++; $display("FAIL async_reset_ctrl got %h want 000", o1.ctrl); end
        if (i1.ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready got %b want 1", i1.ready); end
        if (stall1 !== 16'd0) begin errors++; $display("FAIL async_reset_stall got %0d want 0", stall1); end
        @(negedge clk);
        rst_n = 1'b1;
        clearModels();
        o1.ready = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_streaming();
        beat_t b;
        o1.ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            b = mkBeat(DW'(k), CW'(k));
            drive1(1'b1, b);
            tick();
            checks += 3;
            if (o1.valid !== 1'b1) begin errors++; $display("FAIL stream_valid beat %0d got %b want 1", k, o1.valid); end
            if (o1.rd1 !== DW'(k)) begin errors++; $display("FAIL stream_rd1 got %0d want %0d", o1.rd1, k); end
            if (i1.ready !== 1'b1) begin errors++; $display("FAIL stream_ready got %b want 1", i1.ready); end
            $display("stream beat rd1=%0d out_rd1=%0d", k, o1.rd1);
        end
        drive1(1'b0, b);
        tick();
        checks += 2;
        if (o1.valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got %b want 0", o1.valid); end
        if (o1.ctrl !== 9'h000) begin errors++; $display("FAIL stream_bubble_ctrl got %h want 000", o1.ctrl); end
    endtask

    task automatic test_stall();
        beat_t a, b;
        o1.ready = 1'b0;
        a = mkBeat(32'hA, 9'h0A5); drive1(1'b1, a); tick();
        checks += 2;
        if (o1.rd1 !== 32'hA) begin errors++; $display("FAIL stall_first got %h want A", o1.rd1); end
        if (i1.ready !== 1'b1) begin errors++; $display("FAIL stall_ready1 got %b want 1", i1.ready); end
        b = mkBeat(32'hB, 9'h05A); drive1(1'b1, b); tick();
        drive1(1'b0, b);
        checks += 2;
        if (i1.ready !== 1'b0) begin errors++; $display("FAIL stall_ready2 got %b want 0", i1.ready); end
        if (out1() !== a) begin errors++; $display("FAIL stall_hold got %h want %h", out1(), a); end
        repeat (3) tick();
        checks += 2;
        if (out1() !== a) begin errors++; $display("FAIL stall_hold_long got %h want %h", out1(), a); end
        if (stall1 !== 16'(m1Stall)) begin errors++; $display("FAIL stall_count got %0d want %0d", stall1, m1Stall); end
        o1.ready = 1'b1;
        tick();
        checks += 1;
        if (out1() !== b) begin errors++; $display("FAIL stall_release_second got %h want %h", out1(), b); end
        tick();
        checks += 1;
        if (o1.valid !== 1'b0) begin errors++; $display("FAIL stall_release_empty got %b want 0", o1.valid); end
        $display("stall released, stall_cnt=%0d", stall1);
    endtask

    task automatic test_flush();
        beat_t b;
        o1.ready = 1'b0;
        b = mkBeat(32'h11, 9'h1FF); drive1(1'b1, b); tick();
        b = mkBeat(32'h22, 9'h1FF); drive1(1'b1, b); tick();
        checks += 1;
        if (i1.ready !== 1'b0) begin errors++; $display("FAIL flush_full_ready got %b want 0", i1.ready); end
        flush = 1'b1;
        b = mkBeat(32'h33, 9'h1FF); drive1(1'b1, b); tick();
        flush = 1'b0;
        drive1(1'b0, b);
        checks += 3;
        if (o1.valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", o1.valid); end
        if (o1.ctrl !== 9'h000) begin errors++; $display("FAIL flush_ctrl got %h want 000", o1.ctrl); end
        if (i1.ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", i1.ready); end
        o1.ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks += 1;
            if (o1.valid !== 1'b0) begin errors++; $display("FAIL flush_stale cycle %0d got %b want 0", k, o1.valid); end
        end
        // Flush together with a consume and an accepted beat: everything disappears.
        o1.ready = 1'b0;
        b = mkBeat(32'h44, 9'h1FF); drive1(1'b1, b); tick();
        o1.ready = 1'b1;
        flush = 1'b1;
        b = mkBeat(32'h55, 9'h1FF); drive1(1'b1, b);
        checks += 1;
        if (i1.ready !== 1'b1) begin errors++; $display("FAIL flush_accept_ready got %b want 1", i1.ready); end
        tick();
        flush = 1'b0;
        drive1(1'b0, b);
        checks += 2;
        if (o1.valid !== 1'b0) begin errors++; $display("FAIL flush_consume_valid got %b want 0", o1.valid); end
        if (o1.ctrl !== 9'h000) begin errors++; $display("FAIL flush_consume_ctrl got %h want 000", o1.ctrl); end
        tick();
        checks += 1;
        if (o1.valid !== 1'b0) begin errors++; $display("FAIL flush_discard got %b want 0", o1.valid); end
        $display("flush scenarios done");
    endtask

    task automatic test_skid0();
        beat_t b;
        o0.ready = 1'b0;
        b = mkBeat(32'h5, 9'h100); drive0(1'b1, b); tick();
        drive0(1'b0, b);
        #1;
        checks += 2;
        if (o0.valid !== 1'b1) begin errors++; $display("FAIL skid0_valid got %b want 1", o0.valid); end
        if (i0.ready !== 1'b0) begin errors++; $display("FAIL skid0_full_ready got %b want 0", i0.ready); end
        o0.ready = 1'b1;
        b = mkBeat(32'h6, 9'h101); drive0(1'b1, b);
        #1;
        checks += 1;
        if (i0.ready !== 1'b1) begin errors++; $display("FAIL skid0_comb_ready got %b want 1", i0.ready); end
        tick();
        drive0(1'b0, b);
        checks += 2;
        if (out0() !== b) begin errors++; $display("FAIL skid0_load got %h want %h", out0(), b); end
        if (stall0 !== 16'(m0Stall)) begin errors++; $display("FAIL skid0_stall got %0d want %0d", stall0, m0Stall); end
        tick();
        $display("skid0 beat rd1=%0d delivered", o0.rd1);
    endtask

    task automatic test_back_to_back();
        beat_t b;
        for (int n = 0; n < 400; n++) begin
            b = mkBeat($urandom, CW'($urandom_range(0, 511)));
            drive1($urandom_range(0, 3) != 0, b);
            b = mkBeat($urandom, CW'($urandom_range(0, 511)));
            drive0($urandom_range(0, 3) != 0, b);
            o1.ready = ($urandom_range(0, 2) != 0);
            o0.ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 19) == 0);
            #1;
            checks += 2;
            if (i1.ready !== (q1.size() < 2)) begin errors++; $display("FAIL rnd_ready1 cyc %0d got %b want %b", n, i1.ready, q1.size() < 2); end
            if (i0.ready !== (q0.size() == 0 || o0.ready)) begin errors++; $display("FAIL rnd_ready0 cyc %0d got %b", n, i0.ready); end
            tick();
            checks += 4;
            if (o1.valid !== (q1.size() != 0)) begin errors++; $display("FAIL rnd_valid1 cyc %0d got %b want %b", n, o1.valid, q1.size() != 0); end
            else if (q1.size() != 0 && out1() !== q1[0]) begin errors++; $display("FAIL rnd_beat1 cyc %0d got %h want %h", n, out1(), q1[0]); end
            else if (q1.size() == 0 && o1.ctrl !== 9'h000) begin errors++; $display("FAIL rnd_bubble1 cyc %0d got %h want 000", n, o1.ctrl); end
            if (o0.valid !== (q0.size() != 0)) begin errors++; $display("FAIL rnd_valid0 cyc %0d got %b want %b", n, o0.valid, q0.size() != 0); end
            else if (q0.size() != 0 && out0() !== q0[0]) begin errors++; $display("FAIL rnd_beat0 cyc %0d got %h want %h", n, out0(), q0[0]); end
            else if (q0.size() == 0 && o0.ctrl !== 9'h000) begin errors++; $display("FAIL rnd_bubble0 cyc %0d got %h want 000", n, o0.ctrl); end
            if (stall1 !== 16'(m1Stall)) begin errors++; $display("FAIL rnd_stall1 cyc %0d got %0d want %0d", n, stall1, m1Stall); end
            if (stall0 !== 16'(m0Stall)) begin errors++; $display("FAIL rnd_stall0 cyc %0d got %0d want %0d", n, stall0, m0Stall); end
            if (n % 50 == 0) $display("rnd cyc %0d q1=%0d q0=%0d stall1=%0d stall0=%0d", n, q1.size(), q0.size(), stall1, stall0);
        end
        flush = 1'b0;
        drive1(1'b0, b);
        drive0(1'b0, b);
    endtask

    task automatic test_saturation();
        beat_t b;
        oSat.ready = 1'b0;
        b = mkBeat(32'h77, 9'h1FF);
        driveS(1'b1, b); tick();
        driveS(1'b0, b);
        checks += 1;
        if (stallS !== 4'd0) begin errors++; $display("FAIL sat_start got %0d want 0", stallS); end
        repeat (14) tick();
        checks += 1;
        if (stallS !== 4'd14) begin errors++; $display("FAIL sat_14 got %0d want 14", stallS); end
        tick();
        checks += 1;
        if (stallS !== 4'd15) begin errors++; $display("FAIL sat_15 got %0d want 15", stallS); end
        repeat (5) tick();
        checks += 2;
        if (stallS !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", stallS); end
        if (oSat.rd1 !== 32'h77) begin errors++; $display("FAIL sat_data got %h want 77", oSat.rd1); end
        $display("saturation stall_cnt=%0d", stallS);
    endtask

    initial begin
        beat_t z;
        z = '0;
        drive1(1'b0, z);
        drive0(1'b0, z);
        driveS(1'b0, z);
        o1.ready = 1'b1;
        o0.ready = 1'b1;
        oSat.ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clearModels();
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_skid0();
        test_back_to_back();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dec_exe_pipe_reg.md
Name: dec_exe_pipe_reg

Overview:
Parametrised Decode/Execute pipeline register for the pipelined MIPS core. It carries the decoded control bundle, register operands, the sign-extended immediate, register addresses and PC+4 from Decode to Execute. It adds a valid/ready handshake, an optional skid buffer for stalls, a synchronous flush for branch squash with bubble insertion, and a saturating stall-cycle counter.

Parameters:
DATA_W, 32, width of rd1/rd2/imm/pcplus4 fields
REG_ADDR_W, 5, width of each of rs/rt/rd address fields
CTRL_W, 9, control bundle width; bit map {RegWrite, MemtoReg, MemWrite, Branch, ALUControl[2:0], ALUSrc, RegDst}, MSB first
SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single register (combinational in_ready)
STALL_CNT_W, 16, width of stall counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all held and incoming beats
in_valid  in  1  Decode beat valid
in_ready  out  1  register can accept a beat
in_ctrl  in  CTRL_W  control bundle (D stage)
in_rd1  in  DATA_W  register-file read data 1
in_rd2  in  DATA_W  register-file read data 2
in_imm  in  DATA_W  sign-extended immediate
in_pcplus4  in  DATA_W  PC+4
in_rs, in_rt, in_rd  in  REG_ADDR_W each  register addresses
out_valid  out  1  Execute beat valid
out_ready  in  1  Execute can consume
out_ctrl  out  CTRL_W  control bundle (E stage); all zero when out_valid=0
out_rd1, out_rd2, out_imm, out_pcplus4  out  DATA_W each  held data
out_rs, out_rt, out_rd  out  REG_ADDR_W each  held addresses
stall_cnt  out  STALL_CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset (rst_n=0, asynchronous): m_valid=0, s_valid=0, all field registers 0, stall_cnt=0. Outputs read out_valid=0 and out_ctrl=0. Asserting reset mid-stall discards all held beats.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready. out_valid = m_valid.
- Latency: an accepted beat appears on outputs the next cycle when M is empty or being consumed.
- SKID=1: main register M plus skid register S. in_ready = !s_valid, driven from a register with no combinational path from out_ready.
  - M empty or consumed, S valid: M<=S, S cleared; S may reload in the same cycle only if Accept.
  - M empty or consumed, S empty: M<=input if Accept, else m_valid<=0.
  - M held (valid and not consumed) and Accept: S<=input.
  - Order is FIFO. No beat is dropped or duplicated.
- SKID=0: in_ready = !m_valid | out_ready (combinational). M loads on Accept; m_valid clears on Consume without Accept.
- Flush (synchronous, highest priority after reset): next cycle m_valid=0 and s_valid=0. A beat accepted in the flush cycle is discarded. Data registers may retain stale values; out_ctrl is forced to 0 because it is gated by m_valid.
- Bubble: whenever out_valid=0, out_ctrl=0, so downstream RegWrite/MemWrite are never asserted by a bubble. Data outputs are don't-care.
- Field loading: data and address registers load only on the transfer into M or S. When not loading they hold their value (stall holds outputs stable).
- stall_cnt: increments by 1 each cycle out_valid=1 and out_ready=0. Saturates at 2^STALL_CNT_W-1, with no wrap. Cleared only by reset. Flush does not clear it.
- Simultaneous flush and out_ready: the beat in M counts as consumed by Execute in that cycle, and the register is still empty next cycle.

Test Plan:
- Reset: drive rst_n=0 asynchronously between clock edges -> out_valid=0, out_ctrl=0, in_ready=1, stall_cnt=0 immediately, without waiting for a clock edge.
- Streaming: out_ready=1, feed beats with in_rd1=1,2,3,4 on consecutive cycles -> out_rd1=1,2,3,4 on the following consecutive cycles, in_ready stays 1.
- Stall with SKID=1: out_ready=0, send in_rd1=0xA then 0xB -> in_ready=0 after the second beat, out_rd1 holds 0xA, stall_cnt counts cycles. Release out_ready -> 0xA then 0xB emerge in order.
- Flush: M and S full (ctrl=9'h1FF), assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and no stale beat appears later.
- Saturation: STALL_CNT_W=4, hold a valid beat with out_ready=0 for 20 cycles -> stall_cnt=15 and stays there.
- SKID=0: out_ready=0 with M full -> in_ready=0 in the same cycle. Set out_ready=1 -> in_ready=1 combinationally, and the new beat loads the next cycle.
